// File: rtl/pcs_lane_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pcs_lane_pkg
// Purpose  : Shared types, sync-header constants and helpers for the
//            25G PCS lane lock sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package pcs_lane_pkg;

  // Lane lock sequencer states
  typedef enum logic [1:0] {
    UNLOCK   = 2'd0,
    SLIPWAIT = 2'd1,
    LOCKED   = 2'd2
  } lane_state_t;

  // The only two legal 64b/66b sync headers
  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;

  // Number of illegal sync headers among the four carried with one beat
  function automatic logic [2:0] count_bad_sh(input logic [7:0] sh);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if ((sh[2*i +: 2] != SH_DATA) && (sh[2*i +: 2] != SH_CTRL)) begin
        n = n + 3'd1;
      end
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pcs_lane_hiber_mon.sv
`default_nettype none
// ============================================================================
// Module   : pcs_lane_hiber_mon
// Purpose  : Hi-BER monitor. Counts illegal sync headers over fixed windows of
//            clk cycles while the lane is locked and updates the hi-BER flag
//            at the end of every window.
// Revision : 1.0 - initial release
// ============================================================================
module pcs_lane_hiber_mon #(
  parameter int HIBER_WINDOW = 3125,
  parameter int HIBER_THRESH = 97
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       run,
  input  logic       beat_valid,
  input  logic [2:0] nbad,
  output logic       hi_ber
);

  localparam int          TW   = $clog2(HIBER_WINDOW) + 1;
  localparam int          CW   = $clog2(HIBER_THRESH) + 1;
  localparam int unsigned CMAX = (1 << CW) - 1;

  logic [TW-1:0] timer;
  logic [CW-1:0] count;
  logic [31:0]   sum;
  logic [31:0]   sat_sum;
  logic          window_end;

  // Count including this cycle's beat; the stored count saturates, which is
  // harmless because it only ever needs to reach the threshold.
  assign sum        = 32'(count) + (beat_valid ? 32'(nbad) : 32'd0);
  assign sat_sum    = (sum > CMAX) ? CMAX : sum;
  assign window_end = (timer == TW'(HIBER_WINDOW - 1));

  // Window timer, error accumulator and flag; leaving lock restarts the window
  // but the flag keeps its last verdict
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      timer  <= '0;
      count  <= '0;
      hi_ber <= 1'b0;
    end else if (!run) begin
      timer <= '0;
      count <= '0;
    end else if (window_end) begin
      hi_ber <= (sum >= 32'(HIBER_THRESH));
      timer  <= '0;
      count  <= '0;
    end else begin
      timer <= timer + 1'b1;
      count <= sat_sum[CW-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/pcs_lane_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pcs_lane_lock_ctrl
// Purpose  : Per-lane receive sequencer: 64b/66b block lock on four sync
//            headers per 256-bit beat, gearbox slip requests, descrambler
//            enable/valid gating and warm-up error flagging.
//            Optional hi-BER monitor enabled by defining PCS_LANE_HIBER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pcs_lane_lock_ctrl
  import pcs_lane_pkg::*;
#(
  parameter int GOOD_CNT_TGT = 64,
  parameter int WINDOW       = 64,
  parameter int BAD_CNT_MAX  = 16,
  parameter int SLIP_WAIT    = 4,
  parameter int HIBER_WINDOW = 3125,
  parameter int HIBER_THRESH = 97
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_enable,
  input  logic [7:0] in_sh,
  input  logic       in_sh_valid,
  output logic       out_slip,
  output logic       out_block_lock,
  output logic       out_desc_enable,
  output logic       out_desc_valid,
  output logic       out_data_error,
  output logic       out_hi_ber
);

  localparam int GW = $clog2(GOOD_CNT_TGT) + 1;
  localparam int SW = $clog2(WINDOW) + 1;
  localparam int BW = $clog2(BAD_CNT_MAX) + 1;
  localparam int WW = $clog2(SLIP_WAIT) + 1;

  lane_state_t state, state_nx;
  logic [GW-1:0] good_cnt, good_nx;
  logic [SW-1:0] sh_cnt, sh_nx;
  logic [BW-1:0] bad_cnt, bad_nx;
  logic [WW-1:0] wait_cnt, wait_nx;
  logic          warmup, warmup_nx;
  logic          slip_nx;
  logic [2:0]    nbad;
  logic [31:0]   good_sum, sh_sum, bad_sum, wait_sum;

  assign nbad = count_bad_sh(in_sh);

  // Candidate counter values evaluated at 32 bits so the threshold compares
  // cannot wrap in the narrow registers
  assign good_sum = 32'(good_cnt) + 32'd4;
  assign sh_sum   = 32'(sh_cnt) + 32'd4;
  assign bad_sum  = 32'(bad_cnt) + 32'(nbad);
  assign wait_sum = 32'(wait_cnt) + 32'd1;

  // State register plus counters, warm-up flag and registered status outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= UNLOCK;
      good_cnt       <= '0;
      sh_cnt         <= '0;
      bad_cnt        <= '0;
      wait_cnt       <= '0;
      warmup         <= 1'b0;
      out_slip       <= 1'b0;
      out_block_lock <= 1'b0;
    end else begin
      state          <= state_nx;
      good_cnt       <= good_nx;
      sh_cnt         <= sh_nx;
      bad_cnt        <= bad_nx;
      wait_cnt       <= wait_nx;
      warmup         <= warmup_nx;
      out_slip       <= slip_nx;
      out_block_lock <= (state_nx == LOCKED);
    end
  end

  // Next-state and counter update; a dropped lane enable overrides any slip
  always_comb begin
    state_nx  = state;
    good_nx   = good_cnt;
    sh_nx     = sh_cnt;
    bad_nx    = bad_cnt;
    wait_nx   = wait_cnt;
    warmup_nx = warmup;
    slip_nx   = 1'b0;
    if (!in_enable) begin
      state_nx  = UNLOCK;
      good_nx   = '0;
      sh_nx     = '0;
      bad_nx    = '0;
      wait_nx   = '0;
      warmup_nx = 1'b0;
    end else if (in_sh_valid) begin
      case (state)
        UNLOCK: begin
          if (nbad == 3'd0) begin
            if (good_sum >= 32'(GOOD_CNT_TGT)) begin
              state_nx  = LOCKED;
              good_nx   = '0;
              sh_nx     = '0;
              bad_nx    = '0;
              wait_nx   = '0;
              warmup_nx = 1'b1;
            end else begin
              good_nx = good_sum[GW-1:0];
            end
          end else begin
            slip_nx  = 1'b1;
            good_nx  = '0;
            state_nx = SLIPWAIT;
          end
        end
        SLIPWAIT: begin
          if (wait_sum >= 32'(SLIP_WAIT)) begin
            wait_nx  = '0;
            state_nx = UNLOCK;
          end else begin
            wait_nx = wait_sum[WW-1:0];
          end
        end
        LOCKED: begin
          // This beat is forwarded, so the descrambler is now primed
          warmup_nx = 1'b0;
          if (bad_sum >= 32'(BAD_CNT_MAX)) begin
            slip_nx  = 1'b1;
            state_nx = SLIPWAIT;
            good_nx  = '0;
            sh_nx    = '0;
            bad_nx   = '0;
            wait_nx  = '0;
          end else if (sh_sum >= 32'(WINDOW)) begin
            sh_nx  = '0;
            bad_nx = '0;
          end else begin
            sh_nx  = sh_sum[SW-1:0];
            bad_nx = bad_sum[BW-1:0];
          end
        end
        default: begin
          state_nx = UNLOCK;
        end
      endcase
    end
  end

  // Descrambler gating, zero latency from the beat inputs
  always_comb begin
    out_desc_enable = in_enable & (state == LOCKED);
    out_desc_valid  = in_enable & in_sh_valid & (state == LOCKED);
    out_data_error  = out_desc_valid & (warmup | (nbad != 3'd0));
  end

`ifdef PCS_LANE_HIBER_EN
  pcs_lane_hiber_mon #(
    .HIBER_WINDOW (HIBER_WINDOW),
    .HIBER_THRESH (HIBER_THRESH)
  ) u_hiber_mon (
    .clk        (clk),
    .reset_n    (reset_n),
    .run        (in_enable & (state == LOCKED)),
    .beat_valid (in_sh_valid),
    .nbad       (nbad),
    .hi_ber     (out_hi_ber)
  );
`else
  // Hi-BER parameters stay in the interface so both builds instantiate alike;
  // here they only feed a constant that is masked off.
  localparam logic HIBER_CFG_SET = (HIBER_WINDOW > 0) && (HIBER_THRESH > 0);
  assign out_hi_ber = HIBER_CFG_SET & 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pcs_lane_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcs_lane_lock_ctrl
// Purpose  : Self-checking bench for pcs_lane_lock_ctrl: directed scenarios
//            followed by randomized traffic, all compared every cycle against
//            a behavioural model of the lane lock rules.
//            Hi-BER checks are active when PCS_LANE_HIBER_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcs_lane_lock_ctrl;

  localparam int GOOD_TGT = 64;
  localparam int WIN      = 64;
  localparam int BAD_MAX  = 16;
  localparam int SWAIT    = 4;
  localparam int HWIN     = 100;
  localparam int HTHR     = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_enable = 1'b0;
  logic [7:0] in_sh = 8'h00;
  logic       in_sh_valid = 1'b0;
  logic       out_slip, out_block_lock, out_desc_enable;
  logic       out_desc_valid, out_data_error, out_hi_ber;

  always #5 clk = ~clk;

  pcs_lane_lock_ctrl #(
    .GOOD_CNT_TGT (GOOD_TGT),
    .WINDOW       (WIN),
    .BAD_CNT_MAX  (BAD_MAX),
    .SLIP_WAIT    (SWAIT),
    .HIBER_WINDOW (HWIN),
    .HIBER_THRESH (HTHR)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .in_enable       (in_enable),
    .in_sh           (in_sh),
    .in_sh_valid     (in_sh_valid),
    .out_slip        (out_slip),
    .out_block_lock  (out_block_lock),
    .out_desc_enable (out_desc_enable),
    .out_desc_valid  (out_desc_valid),
    .out_data_error  (out_data_error),
    .out_hi_ber      (out_hi_ber)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: lock flag, headers collected toward lock, headers and
  // errors seen in the current window, beats still to discard after a slip.
  bit m_locked   = 1'b0;
  bit m_warm     = 1'b0;
  bit m_slip     = 1'b0;
  bit m_hiber    = 1'b0;
  int m_good     = 0;
  int m_win      = 0;
  int m_bad      = 0;
  int m_discard  = 0;
  int m_htimer   = 0;
  int m_hcnt     = 0;
  bit model_on   = 1'b0;
  logic last_dv  = 1'b0;
  logic last_err = 1'b0;

  function automatic int nbad_of(input logic [7:0] sh);
    int n;
    logic [1:0] h;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      h = sh[2*i +: 2];
      if (!(h == 2'b01 || h == 2'b10)) n++;
    end
    return n;
  endfunction

  function automatic logic [7:0] rand_sh(input int rate);
    logic [7:0] s;
    s = 8'h00;
    for (int i = 0; i < 4; i++) begin
      if (rate != 0 && $urandom_range(0, rate - 1) == 0)
        s[2*i +: 2] = ($urandom_range(0, 1) != 0) ? 2'b00 : 2'b11;
      else
        s[2*i +: 2] = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
    end
    return s;
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic clear_lane();
    m_locked  = 1'b0;
    m_warm    = 1'b0;
    m_good    = 0;
    m_win     = 0;
    m_bad     = 0;
    m_discard = 0;
  endtask

  task automatic model_update(input logic rn, input logic en, input logic v, input int nb);
    bit nx_slip;
    nx_slip = 1'b0;
    if (!rn) begin
      clear_lane();
      m_hiber  = 1'b0;
      m_htimer = 0;
      m_hcnt   = 0;
    end else begin
`ifdef PCS_LANE_HIBER_EN
      if (en && m_locked) begin
        if (m_htimer == HWIN - 1) begin
          m_hiber  = ((m_hcnt + (v ? nb : 0)) >= HTHR);
          m_hcnt   = 0;
          m_htimer = 0;
        end else begin
          m_htimer++;
          m_hcnt += (v ? nb : 0);
        end
      end else begin
        m_htimer = 0;
        m_hcnt   = 0;
      end
`endif
      if (!en) begin
        clear_lane();
      end else if (v) begin
        if (m_locked) begin
          m_warm = 1'b0;
          m_win += 4;
          m_bad += nb;
          if (m_bad >= BAD_MAX) begin
            nx_slip = 1'b1;
            clear_lane();
            m_discard = SWAIT;
          end else if (m_win >= WIN) begin
            m_win = 0;
            m_bad = 0;
          end
        end else if (m_discard > 0) begin
          m_discard--;
        end else if (nb == 0) begin
          m_good += 4;
          if (m_good >= GOOD_TGT) begin
            clear_lane();
            m_locked = 1'b1;
            m_warm   = 1'b1;
          end
        end else begin
          nx_slip   = 1'b1;
          m_good    = 0;
          m_discard = SWAIT;
        end
      end
    end
    m_slip = nx_slip;
  endtask

  // One clock cycle: drive inputs, check all outputs mid-cycle, advance model
  task automatic step(input logic rn, input logic en, input logic v, input logic [7:0] sh);
    int nb;
    logic e_dv;
    reset_n     = rn;
    in_enable   = en;
    in_sh_valid = v;
    in_sh       = sh;
    #3;
    nb       = nbad_of(sh);
    e_dv     = en & v & m_locked;
    last_dv  = out_desc_valid;
    last_err = out_data_error;
    if (model_on) begin
      chk("desc_enable", out_desc_enable, en & m_locked);
      chk("desc_valid", out_desc_valid, e_dv);
      chk("data_error", out_data_error, e_dv & (m_warm | (nb != 0)));
      chk("slip", out_slip, m_slip);
      chk("block_lock", out_block_lock, m_locked);
      chk("hi_ber", out_hi_ber, m_hiber);
    end
    model_update(rn, en, v, nb);
    @(posedge clk);
    #1;
  endtask

  task automatic clean_beats(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b1, 8'h66);
  endtask

  initial begin
    int rates[4];
    rates = '{0, 200, 30, 8};

    // Reset
    step(1'b0, 1'b1, 1'b0, 8'h00);
    model_on = 1'b1;
    step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("reset_slip", out_slip, 1'b0);
    chk("reset_lock", out_block_lock, 1'b0);
    chk("reset_hiber", out_hi_ber, 1'b0);
    chk("reset_desc_en", out_desc_enable, 1'b0);

    // Clean lock: 16 beats of good headers
    clean_beats(15);
    chk("lock_not_before_16", out_block_lock, 1'b0);
    clean_beats(1);
    chk("lock_after_16", out_block_lock, 1'b1);
    clean_beats(1);
    chk("beat17_valid", last_dv, 1'b1);
    chk("beat17_warmup_err", last_err, 1'b1);
    clean_beats(1);
    chk("beat18_no_err", last_err, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 8'h00);

    // Loss of lock: four all-bad beats
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 8'h00);
    chk("lol_held_at_12", out_block_lock, 1'b1);
    step(1'b1, 1'b1, 1'b1, 8'h00);
    chk("lol_beat_fwd", last_dv, 1'b1);
    chk("lol_beat_err", last_err, 1'b1);
    chk("lol_slip", out_slip, 1'b1);
    chk("lol_lock_fall", out_block_lock, 1'b0);
    clean_beats(1);
    chk("lol_slip_one_cycle", out_slip, 1'b0);

    // Remaining slip-wait beats, then slip during acquisition on beat 5
    clean_beats(3);
    clean_beats(4);
    step(1'b1, 1'b1, 1'b1, 8'h64);
    chk("acq_slip", out_slip, 1'b1);
    clean_beats(4);
    chk("acq_slip_cleared", out_slip, 1'b0);
    clean_beats(15);
    chk("acq_no_lock_yet", out_block_lock, 1'b0);
    clean_beats(1);
    chk("acq_relock", out_block_lock, 1'b1);

    // Window reset: 15 bad headers per 16-beat window, twice
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 15; i++) step(1'b1, 1'b1, 1'b1, 8'h64);
      clean_beats(1);
    end
    chk("window_lock_held", out_block_lock, 1'b1);

    // Soft reset for one cycle while locked
    step(1'b1, 1'b0, 1'b1, 8'h66);
    chk("soft_lock", out_block_lock, 1'b0);
    chk("soft_slip", out_slip, 1'b0);
    clean_beats(15);
    chk("soft_no_lock_15", out_block_lock, 1'b0);
    clean_beats(1);
    chk("soft_relock", out_block_lock, 1'b1);

`ifdef PCS_LANE_HIBER_EN
    // Hi-BER: 8 bad headers in the first window after lock, then clean
    for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b1, 8'h00);
    for (int i = 0; i < HWIN; i++) step(1'b1, 1'b1, 1'b0, 8'h00);
    chk("hiber_set", out_hi_ber, 1'b1);
    clean_beats(HWIN);
    chk("hiber_clear", out_hi_ber, 1'b0);
`endif

    // Randomized traffic with varying header error rates
    for (int seg = 0; seg < 8; seg++) begin
      for (int i = 0; i < 200; i++) begin
        step(($urandom_range(0, 499) != 0),
             ($urandom_range(0, 99) != 0),
             ($urandom_range(0, 3) != 0),
             rand_sh(rates[seg % 4]));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
